// File: rtl/alu_iterative.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/shift/add ops plus iterative
// shift-add multiply and restoring divide, with registered result and flags.
module alu_iterative #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] source,
  input  logic [WIDTH-1:0] destination,
  input  logic             signed_mode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             div_by_zero
);

  if ((WIDTH < 8) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("alu_iterative: WIDTH must be even and >= 8");
  end

  localparam int               H       = WIDTH / 2;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [SHW:0]     ITERS   = (SHW+1)'(WIDTH);

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] s_q, d_q;
  logic             sm_q, cin_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q;
  logic [WIDTH-1:0] result_q, remainder_q;
  logic             carry_q, overflow_q, zero_q, negative_q, dbz_q;

  // Adder shared by A, B and E; B adds ~S with a forced carry of 1.
  logic [WIDTH-1:0] addend;
  logic             add_cin;
  logic [WIDTH:0]   sum_d;
  logic             shift_big;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shl_d, shr_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addend    = (op_q == 4'hB) ? ~s_q : s_q;
    add_cin   = (op_q == 4'hB) ? 1'b1 : ((op_q == 4'hE) ? cin_q : 1'b0);
    sum_d     = {1'b0, d_q} + {1'b0, addend} + {{WIDTH{1'b0}}, add_cin};
    shift_big = (s_q >= WIDTH_V);
    shamt     = s_q[SHW-1:0];
    shl_d     = shift_big ? '0 : (d_q << shamt);
    if (shift_big)
      shr_d = sm_q ? {WIDTH{d_q[WIDTH-1]}} : '0;
    else
      shr_d = sm_q ? $unsigned($signed(d_q) >>> shamt) : (d_q >> shamt);
  end

  // One step of each iterative unit: {acc,mq} holds the product or remainder/quotient.
  logic [WIDTH:0]   mul_sum_d;
  logic [WIDTH:0]   div_shift_d, div_trial_d;
  logic             qbit_d;

  always_comb begin
    mul_sum_d   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, s_q} : '0);
    div_shift_d = {acc_q, mq_q[WIDTH-1]};
    div_trial_d = div_shift_d - {1'b0, s_q};
    qbit_d      = ~div_trial_d[WIDTH];
  end

  // Values loaded into the output registers when entering DONE.
  logic [WIDTH-1:0] ld_res_d, ld_rem_d;
  logic             ld_carry_d, ld_ovf_d, ld_dbz_d;

  always_comb begin
    ld_res_d   = '0;
    ld_rem_d   = '0;
    ld_carry_d = 1'b0;
    ld_ovf_d   = 1'b0;
    ld_dbz_d   = 1'b0;
    case (state_q)
      MUL: begin
        ld_res_d = (op_q == 4'hC) ? mq_q : acc_q;
        ld_ovf_d = (op_q == 4'hC) && (acc_q != '0);
      end
      DIV: begin
        ld_res_d = mq_q;
        ld_rem_d = acc_q;
      end
      default: begin
        case (op_q)
          4'h0: ld_res_d = s_q;
          4'h1: ld_res_d = s_q & d_q;
          4'h2: ld_res_d = s_q | d_q;
          4'h3: ld_res_d = s_q ^ d_q;
          4'h4: ld_res_d = '0 - s_q;
          4'h5: ld_res_d = shl_d;
          4'h6: ld_res_d = shr_d;
          4'h7: ld_res_d = {s_q[H-1:0], s_q[WIDTH-1:H]};
          4'h8: ld_res_d = {s_q[WIDTH-1:H], {H{1'b0}}};
          4'h9: ld_res_d = {{H{1'b0}}, s_q[H-1:0]};
          4'hA, 4'hB, 4'hE: begin
            ld_res_d   = sum_d[WIDTH-1:0];
            ld_carry_d = sum_d[WIDTH];
            ld_ovf_d   = (d_q[WIDTH-1] == addend[WIDTH-1]) &&
                         (sum_d[WIDTH-1] != d_q[WIDTH-1]);
          end
          4'hF: begin
            // Only reached with S == 0; a real divide goes through DIV.
            ld_res_d = '1;
            ld_rem_d = d_q;
            ld_dbz_d = 1'b1;
          end
          default: ld_res_d = '0;
        endcase
      end
    endcase
  end

  // NOTE: the whole datapath is reset so every output reads 0 during reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      s_q         <= '0;
      d_q         <= '0;
      sm_q        <= 1'b0;
      cin_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in the same edge.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op_code;
            s_q   <= source;
            d_q   <= destination;
            sm_q  <= signed_mode;
            cin_q <= carry_in;
            cnt_q <= '0;
            acc_q <= '0;
            mq_q  <= destination;
            if ((op_code == 4'hC) || (op_code == 4'hD))
              state_q <= MUL;
            else if ((op_code == 4'hF) && (source != '0))
              state_q <= DIV;
            else
              state_q <= EXEC;
          end
        end
        MUL, DIV: begin
          if (cnt_q == ITERS) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + (SHW+1)'(1);
            if (state_q == MUL) begin
              acc_q <= mul_sum_d[WIDTH:1];
              mq_q  <= {mul_sum_d[0], mq_q[WIDTH-1:1]};
            end else begin
              acc_q <= qbit_d ? div_trial_d[WIDTH-1:0] : div_shift_d[WIDTH-1:0];
              mq_q  <= {mq_q[WIDTH-2:0], qbit_d};
            end
          end
        end
        EXEC:    state_q <= DONE;
        DONE:    if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if ((state_q == EXEC) || (((state_q == MUL) || (state_q == DIV)) && (cnt_q == ITERS))) begin
        result_q    <= ld_res_d;
        remainder_q <= ld_rem_d;
        carry_q     <= ld_carry_d;
        overflow_q  <= ld_ovf_d;
        zero_q      <= (ld_res_d == '0);
        negative_q  <= ld_res_d[WIDTH-1];
        dbz_q       <= ld_dbz_d;
      end
    end
  end

  assign in_ready    = (state_q == IDLE) && !reset;
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign carry       = carry_q;
  assign overflow    = overflow_q;
  assign zero        = zero_q;
  assign negative    = negative_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: one 16-bit and one 32-bit instance share
// the stimulus bus; use32 selects which one is driven and observed.
module tb_alu_iterative;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, signed_mode, carry_in;
  logic [3:0]  op_code;
  logic [31:0] source, destination;
  logic        use32;

  logic        ir16, ov16, c16, o16, z16, n16, dz16;
  logic [15:0] res16, rem16;
  logic        ir32, ov32, c32, o32, z32, n32, dz32;
  logic [31:0] res32, rem32;

  logic        obs_ir, obs_ov, obs_c, obs_o, obs_z, obs_n, obs_dz;
  logic [31:0] obs_res, obs_rem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  alu_iterative #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid && !use32), .in_ready(ir16),
    .op_code(op_code), .source(source[15:0]), .destination(destination[15:0]),
    .signed_mode(signed_mode), .carry_in(carry_in),
    .out_valid(ov16), .out_ready(out_ready && !use32),
    .result(res16), .remainder(rem16), .carry(c16), .overflow(o16),
    .zero(z16), .negative(n16), .div_by_zero(dz16)
  );

  alu_iterative #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid && use32), .in_ready(ir32),
    .op_code(op_code), .source(source), .destination(destination),
    .signed_mode(signed_mode), .carry_in(carry_in),
    .out_valid(ov32), .out_ready(out_ready && use32),
    .result(res32), .remainder(rem32), .carry(c32), .overflow(o32),
    .zero(z32), .negative(n32), .div_by_zero(dz32)
  );

  always_comb begin
    if (use32) begin
      {obs_ir, obs_ov, obs_c, obs_o, obs_z, obs_n, obs_dz} = {ir32, ov32, c32, o32, z32, n32, dz32};
      obs_res = res32;
      obs_rem = rem32;
    end else begin
      {obs_ir, obs_ov, obs_c, obs_o, obs_z, obs_n, obs_dz} = {ir16, ov16, c16, o16, z16, n16, dz16};
      obs_res = {16'h0, res16};
      obs_rem = {16'h0, rem16};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request, scramble the inputs after acceptance, count cycles to out_valid.
  task automatic run_op(input logic [3:0] op, input logic [31:0] d, input logic [31:0] s,
                        input logic sm, input logic cin, output int lat);
    int guard;
    guard = 0;
    while (!obs_ir && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    op_code = op; destination = d; source = s; signed_mode = sm; carry_in = cin;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    op_code = 4'h3; destination = 32'hA5A5_A5A5; source = 32'h0F0F_0F0F;
    signed_mode = ~sm; carry_in = ~cin;
    lat = 0;
    while (!obs_ov && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  // flags packed as {carry, overflow, zero, negative, div_by_zero}
  task automatic expect_op(input string tag, input logic [3:0] op, input logic [31:0] d,
                           input logic [31:0] s, input logic sm, input logic cin,
                           input int exp_lat, input logic [31:0] e_res,
                           input logic [31:0] e_rem, input logic [4:0] e_flags);
    int lat;
    run_op(op, d, s, sm, cin, lat);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/result"}, obs_res, e_res);
    check({tag, "/remainder"}, obs_rem, e_rem);
    check({tag, "/flags"}, {27'h0, obs_c, obs_o, obs_z, obs_n, obs_dz}, {27'h0, e_flags});
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0;
    carry_in = 1'b0; op_code = 4'h0; source = '0; destination = '0; use32 = 1'b0;

    repeat (3) @(negedge clock);
    check("reset/in_ready_during", {31'h0, obs_ir}, 32'h0);
    check("reset/out_valid", {31'h0, obs_ov}, 32'h0);
    check("reset/outputs", {obs_res[15:0], 9'h0, obs_c, obs_o, obs_z, obs_n, obs_dz, 1'b0},
          32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("reset/in_ready_after", {31'h0, obs_ir}, 32'h1);

    // Reset in the middle of a multiply discards it.
    op_code = 4'hC; destination = 32'h1234; source = 32'h0100; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("midmul/busy", {30'h0, obs_ir, obs_ov}, 32'h0);
    reset = 1'b1;
    #1;
    check("midmul/in_reset", {30'h0, obs_ir, obs_ov}, 32'h0);
    check("midmul/result_cleared", obs_res, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midmul/after_reset", {30'h0, obs_ir, obs_ov}, 32'h2);
    expect_op("midmul/add", 4'hA, 32'd2, 32'd3, 1'b0, 1'b0, 1, 32'd5, 32'h0, 5'b00000);

    // WIDTH=16 directed vectors
    expect_op("w16/add_ovf", 4'hA, 32'h7FFF, 32'h1, 1'b0, 1'b0, 1, 32'h8000, 32'h0, 5'b01010);
    expect_op("w16/sub_borrow", 4'hB, 32'h0, 32'h1, 1'b0, 1'b0, 1, 32'hFFFF, 32'h0, 5'b00010);
    expect_op("w16/adc", 4'hE, 32'hFFFF, 32'h0, 1'b0, 1'b1, 1, 32'h0, 32'h0, 5'b10100);
    expect_op("w16/mul_lo", 4'hC, 32'h1234, 32'h0100, 1'b0, 1'b0, 17, 32'h3400, 32'h0, 5'b01000);
    expect_op("w16/mul_hi", 4'hD, 32'h1234, 32'h0100, 1'b0, 1'b0, 17, 32'h0012, 32'h0, 5'b00000);
    expect_op("w16/div", 4'hF, 32'd1000, 32'd7, 1'b0, 1'b0, 17, 32'd142, 32'd6, 5'b00000);
    expect_op("w16/div0", 4'hF, 32'h55, 32'h0, 1'b0, 1'b0, 1, 32'hFFFF, 32'h55, 5'b00011);
    expect_op("w16/asr", 4'h6, 32'h8000, 32'd4, 1'b1, 1'b0, 1, 32'hF800, 32'h0, 5'b00010);
    expect_op("w16/lsr", 4'h6, 32'h8000, 32'd4, 1'b0, 1'b0, 1, 32'h0800, 32'h0, 5'b00000);
    expect_op("w16/asr_big", 4'h6, 32'h8000, 32'd20, 1'b1, 1'b0, 1, 32'hFFFF, 32'h0, 5'b00010);
    expect_op("w16/shl_big", 4'h5, 32'h1234, 32'd16, 1'b0, 1'b0, 1, 32'h0, 32'h0, 5'b00100);
    expect_op("w16/shl", 4'h5, 32'h0001, 32'd4, 1'b0, 1'b0, 1, 32'h0010, 32'h0, 5'b00000);
    expect_op("w16/swap", 4'h7, 32'h0, 32'h1234, 1'b0, 1'b0, 1, 32'h3412, 32'h0, 5'b00000);
    expect_op("w16/neg", 4'h4, 32'h0, 32'h0001, 1'b0, 1'b0, 1, 32'hFFFF, 32'h0, 5'b00010);

    // Backpressure: hold the result for 10 cycles while a request waits.
    run_op(4'hA, 32'h7FFF, 32'h1, 1'b0, 1'b0, lat);
    check("bp/latency", 32'(lat), 32'd1);
    op_code = 4'h0; source = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp/handshake", {30'h0, obs_ov, obs_ir}, 32'h2);
      check("bp/result", obs_res, 32'h8000);
      check("bp/flags", {27'h0, obs_c, obs_o, obs_z, obs_n, obs_dz}, 32'b01010);
    end
    in_valid = 1'b0;
    release_out();
    check("bp/idle_after", {30'h0, obs_ov, obs_ir}, 32'h1);

    // WIDTH=32 directed vectors
    use32 = 1'b1;
    @(negedge clock);
    expect_op("w32/add_ovf", 4'hA, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1, 32'h8000_0000, 32'h0, 5'b01010);
    expect_op("w32/sub_borrow", 4'hB, 32'h0, 32'h1, 1'b0, 1'b0, 1, 32'hFFFF_FFFF, 32'h0, 5'b00010);
    expect_op("w32/adc", 4'hE, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1, 32'h0, 32'h0, 5'b10100);
    expect_op("w32/mul_lo", 4'hC, 32'h1234_5678, 32'h0100, 1'b0, 1'b0, 33, 32'h3456_7800, 32'h0, 5'b01000);
    expect_op("w32/mul_hi", 4'hD, 32'h1234_5678, 32'h0100, 1'b0, 1'b0, 33, 32'h0000_0012, 32'h0, 5'b00000);
    expect_op("w32/div", 4'hF, 32'd1000, 32'd7, 1'b0, 1'b0, 33, 32'd142, 32'd6, 5'b00000);
    expect_op("w32/div0", 4'hF, 32'h55, 32'h0, 1'b0, 1'b0, 1, 32'hFFFF_FFFF, 32'h55, 5'b00011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
